// File: rtl/scan_display_ctrl_if.sv
// -----------------------------------------------------------------------------
// scan_display_ctrl_if
// Bundles the data/control inputs and the multiplexed drive outputs of the
// scanned seven-segment display controller.
//
// Signals:
//   digit_data  [4*NUM_DIGITS-1:0]  hex nibble per digit, digit 0 at [3:0]
//   dp_in       [NUM_DIGITS-1:0]    decimal point request per digit
//   blank_in    [NUM_DIGITS-1:0]    1 forces the digit dark
//   load                            single-cycle capture strobe
//   brightness  [3:0]               duty level, 0 dimmest .. 15 full
//   an          [NUM_DIGITS-1:0]    anode enables (one-hot active)
//   seg         [6:0]               segments, seg[6]=a .. seg[0]=g
//   dp                              decimal point segment
//   frame_done                      one-cycle pulse after each frame boundary
//
// Modports:
//   master  drives the inputs and observes the outputs
//   slave   the controller side
// -----------------------------------------------------------------------------
interface scan_display_ctrl_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] digit_data;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    load;
    logic [3:0]              brightness;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic                    frame_done;

    modport master (
        output digit_data, dp_in, blank_in, load, brightness,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  digit_data, dp_in, blank_in, load, brightness,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/scan_display_ctrl.sv
// -----------------------------------------------------------------------------
// scan_display_ctrl
// Time-multiplexed driver for a NUM_DIGITS seven-segment display. A prescaler
// produces a scan tick every DIV clocks; each digit slot lasts 16 ticks and
// the 4-bit position inside the slot doubles as the PWM phase for brightness.
// New digit data is captured on a load strobe into a pending set and copied
// to the display set only at a frame boundary, so a frame never tears.
//
// Parameters:
//   NUM_DIGITS  number of digits (2..16)
//   DIV         clk cycles per scan tick (>= 1)
//   ACTIVE_LOW  1: an/seg/dp low-true, 0: high-true (frame_done always high)
//
// Ports:
//   clk    rising-edge system clock
//   reset  synchronous active-high reset
//   bus    scan_display_ctrl_if.slave (data inputs, load, brightness,
//          an/seg/dp/frame_done registered outputs)
//
// Build option:
//   SCAN_DISPLAY_LZB_EN  when defined, leading zeros (above the most
//                        significant nonzero nibble, dp clear) are dark;
//                        digit 0 is never blanked by this rule.
// -----------------------------------------------------------------------------
module scan_display_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int DIV        = 6250,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    scan_display_ctrl_if.slave    bus
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRE_LAST   = PW'(DIV - 1);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);
    localparam logic          INV        = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    // Standard hex font, high-true, bit 6 = a .. bit 0 = g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1111110; // abcdef
            4'h1:    s = 7'b0110000; // bc
            4'h2:    s = 7'b1101101; // abdeg
            4'h3:    s = 7'b1111001; // abcdg
            4'h4:    s = 7'b0110011; // bcfg
            4'h5:    s = 7'b1011011; // acdfg
            4'h6:    s = 7'b1011111; // acdefg
            4'h7:    s = 7'b1110000; // abc
            4'h8:    s = 7'b1111111; // all
            4'h9:    s = 7'b1111011; // abcdfg
            4'hA:    s = 7'b1110111; // abcefg
            4'hB:    s = 7'b0011111; // cdefg
            4'hC:    s = 7'b1001110; // adef
            4'hD:    s = 7'b0111101; // bcdeg
            4'hE:    s = 7'b1001111; // adefg
            4'hF:    s = 7'b1000111; // aefg
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Scan counters
    logic [PW-1:0] pre_r;
    logic [3:0]    sub_r;
    logic [DW-1:0] digit_r;

    // Pending (captured) and display (shown) register sets
    logic [4*NUM_DIGITS-1:0] pend_data_r;
    logic [NUM_DIGITS-1:0]   pend_dp_r;
    logic [NUM_DIGITS-1:0]   pend_blank_r;
    logic                    load_seen_r;
    logic [4*NUM_DIGITS-1:0] disp_data_r;
    logic [NUM_DIGITS-1:0]   disp_dp_r;
    logic [NUM_DIGITS-1:0]   disp_blank_r;

    // Registered outputs
    logic [NUM_DIGITS-1:0] an_r;
    logic [6:0]            seg_r;
    logic                  dp_r;
    logic                  frame_done_r;

    // Combinational helpers
    logic                  tick_s;
    logic                  boundary_s;
    logic [NUM_DIGITS-1:0] lz_dark_s;
    logic [3:0]            cur_nib_s;
    logic                  on_s;
    logic [NUM_DIGITS-1:0] an_next_s;
    logic [6:0]            seg_next_s;
    logic                  dp_next_s;

    assign tick_s     = (pre_r == PRE_LAST);
    assign boundary_s = tick_s && (sub_r == 4'd15) && (digit_r == DIGIT_LAST);

    // Prescaler, slot sub-counter and digit index
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_r   <= '0;
            sub_r   <= 4'd0;
            digit_r <= '0;
        end else if (tick_s) begin
            pre_r <= '0;
            sub_r <= sub_r + 4'd1;
            if (sub_r == 4'd15) begin
                digit_r <= (digit_r == DIGIT_LAST) ? '0 : digit_r + DW'(1);
            end else begin
                digit_r <= digit_r;
            end
        end else begin
            pre_r   <= pre_r + PW'(1);
            sub_r   <= sub_r;
            digit_r <= digit_r;
        end
    end

    // Load capture and frame-synchronous transfer to the display set.
    // A load on the boundary cycle bypasses the pending set so the very next
    // frame already shows it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_data_r  <= '0;
            pend_dp_r    <= '0;
            pend_blank_r <= '0;
            load_seen_r  <= 1'b0;
            disp_data_r  <= '0;
            disp_dp_r    <= '0;
            disp_blank_r <= '0;
        end else begin
            if (bus.load) begin
                pend_data_r  <= bus.digit_data;
                pend_dp_r    <= bus.dp_in;
                pend_blank_r <= bus.blank_in;
            end
            if (boundary_s) begin
                load_seen_r <= 1'b0;
                if (bus.load) begin
                    disp_data_r  <= bus.digit_data;
                    disp_dp_r    <= bus.dp_in;
                    disp_blank_r <= bus.blank_in;
                end else if (load_seen_r) begin
                    disp_data_r  <= pend_data_r;
                    disp_dp_r    <= pend_dp_r;
                    disp_blank_r <= pend_blank_r;
                end
            end else if (bus.load) begin
                load_seen_r <= 1'b1;
            end
        end
    end

`ifdef SCAN_DISPLAY_LZB_EN
    // Leading-zero mask: walk down from the top digit, darkening zero
    // nibbles with dp clear until the first nonzero nibble is met.
    always_comb begin
        logic found;
        found     = 1'b0;
        lz_dark_s = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (disp_data_r[4*i +: 4] != 4'h0) begin
                found = 1'b1;
            end else begin
                found = found;
            end
            lz_dark_s[i] = !found && !disp_dp_r[i];
        end
    end
`else
    assign lz_dark_s = '0;
`endif

    // Next output values from the current scan position (high-true)
    always_comb begin
        cur_nib_s  = disp_data_r[{digit_r, 2'b00} +: 4];
        on_s       = (sub_r <= bus.brightness) && !disp_blank_r[digit_r]
                     && !lz_dark_s[digit_r];
        an_next_s  = '0;
        seg_next_s = 7'b0000000;
        dp_next_s  = 1'b0;
        if (on_s) begin
            an_next_s[digit_r] = 1'b1;
            seg_next_s         = hex_to_seg(cur_nib_s);
            dp_next_s          = disp_dp_r[digit_r];
        end else begin
            an_next_s  = '0;
            seg_next_s = 7'b0000000;
            dp_next_s  = 1'b0;
        end
    end

    // Output registers with polarity applied; frame_done stays high-true
    always_ff @(posedge clk) begin
        if (reset) begin
            an_r         <= {NUM_DIGITS{INV}};
            seg_r        <= {7{INV}};
            dp_r         <= INV;
            frame_done_r <= 1'b0;
        end else begin
            an_r         <= an_next_s ^ {NUM_DIGITS{INV}};
            seg_r        <= seg_next_s ^ {7{INV}};
            dp_r         <= dp_next_s ^ INV;
            frame_done_r <= boundary_s;
        end
    end

    assign bus.an         = an_r;
    assign bus.seg        = seg_r;
    assign bus.dp         = dp_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_scan_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scan_display_ctrl
// Two controller instances (A: 4 digits, DIV=1, low-true; B: 3 digits,
// DIV=3, high-true) share one random stimulus stream. A reference model
// tracks the scan position as a plain cycle count since reset and derives
// digit/slot/boundary arithmetically; data updates follow the frame rules.
// -----------------------------------------------------------------------------
module tb_scan_display_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_data;
    logic [15:0] in_dp;
    logic [15:0] in_blank;
    logic        in_load;
    logic [3:0]  in_bright;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    scan_display_ctrl_if #(.NUM_DIGITS(4)) ifa ();
    scan_display_ctrl_if #(.NUM_DIGITS(3)) ifb ();

    assign ifa.digit_data = in_data[15:0];
    assign ifa.dp_in      = in_dp[3:0];
    assign ifa.blank_in   = in_blank[3:0];
    assign ifa.load       = in_load;
    assign ifa.brightness = in_bright;
    assign ifb.digit_data = in_data[11:0];
    assign ifb.dp_in      = in_dp[2:0];
    assign ifb.blank_in   = in_blank[2:0];
    assign ifb.load       = in_load;
    assign ifb.brightness = in_bright;

    scan_display_ctrl #(.NUM_DIGITS(4), .DIV(1), .ACTIVE_LOW(1)) dut_a (
        .clk   (clk),
        .reset (rst),
        .bus   (ifa)
    );

    scan_display_ctrl #(.NUM_DIGITS(3), .DIV(3), .ACTIVE_LOW(0)) dut_b (
        .clk   (clk),
        .reset (rst),
        .bus   (ifb)
    );

    // Reference font, high-true, bit 6 = a .. bit 0 = g
    logic [6:0] seg_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    int cfg_n   [2] = '{4, 3};
    int cfg_div [2] = '{1, 3};
    int cfg_al  [2] = '{1, 0};

    // Model state per instance
    int          p           [2];
    logic [63:0] m_pend_data [2];
    logic [15:0] m_pend_dp   [2];
    logic [15:0] m_pend_blk  [2];
    bit          m_seen      [2];
    logic [63:0] m_disp_data [2];
    logic [15:0] m_disp_dp   [2];
    logic [15:0] m_disp_blk  [2];
    logic [31:0] e_an  [2];
    logic [31:0] e_seg [2];
    logic [31:0] e_dp  [2];
    logic [31:0] e_fd  [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Predict outputs after the coming edge and advance the model by one clock.
    task automatic model_step(input int u);
        int n, dv, period, t, s, d;
        bit on;
        logic [3:0] nib;
        n      = cfg_n[u];
        dv     = cfg_div[u];
        period = 16 * dv * n;
        if (rst) begin
            e_an[u]  = (cfg_al[u] != 0) ? ((32'd1 << n) - 32'd1) : 32'd0;
            e_seg[u] = (cfg_al[u] != 0) ? 32'h7F : 32'h0;
            e_dp[u]  = (cfg_al[u] != 0) ? 32'd1 : 32'd0;
            e_fd[u]  = 32'd0;
            p[u] = 0;
            m_pend_data[u] = '0; m_pend_dp[u] = '0; m_pend_blk[u] = '0;
            m_disp_data[u] = '0; m_disp_dp[u] = '0; m_disp_blk[u] = '0;
            m_seen[u] = 1'b0;
        end else begin
            t   = p[u] / dv;
            s   = t % 16;
            d   = (t / 16) % n;
            nib = m_disp_data[u][4*d +: 4];
            on  = (s <= int'(in_bright)) && !m_disp_blk[u][d];
            e_an[u]  = on ? (32'd1 << d) : 32'd0;
            e_seg[u] = on ? {25'd0, seg_tab[nib]} : 32'd0;
            e_dp[u]  = (on && m_disp_dp[u][d]) ? 32'd1 : 32'd0;
            if (cfg_al[u] != 0) begin
                e_an[u]  = ~e_an[u] & ((32'd1 << n) - 32'd1);
                e_seg[u] = e_seg[u] ^ 32'h7F;
                e_dp[u]  = e_dp[u] ^ 32'd1;
            end
            e_fd[u] = ((p[u] % period) == period - 1) ? 32'd1 : 32'd0;
            if ((p[u] % period) == period - 1) begin
                if (in_load) begin
                    m_disp_data[u] = in_data; m_disp_dp[u] = in_dp; m_disp_blk[u] = in_blank;
                end else if (m_seen[u]) begin
                    m_disp_data[u] = m_pend_data[u]; m_disp_dp[u] = m_pend_dp[u];
                    m_disp_blk[u]  = m_pend_blk[u];
                end
                m_seen[u] = 1'b0;
            end else if (in_load) begin
                m_seen[u] = 1'b1;
            end
            if (in_load) begin
                m_pend_data[u] = in_data; m_pend_dp[u] = in_dp; m_pend_blk[u] = in_blank;
            end
            p[u]++;
        end
    endtask

    // One clock: model prediction, edge, then compare and drop the strobe.
    task automatic run_cycle();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        cyc++;
        check("A_an",  32'(ifa.an),         e_an[0]);
        check("A_seg", 32'(ifa.seg),        e_seg[0]);
        check("A_dp",  32'(ifa.dp),         e_dp[0]);
        check("A_fd",  32'(ifa.frame_done), e_fd[0]);
        check("B_an",  32'(ifb.an),         e_an[1]);
        check("B_seg", 32'(ifb.seg),        e_seg[1]);
        check("B_dp",  32'(ifb.dp),         e_dp[1]);
        check("B_fd",  32'(ifb.frame_done), e_fd[1]);
        in_load = 1'b0;
    endtask

    task automatic run_n(input int k);
        for (int i = 0; i < k; i++) run_cycle();
    endtask

    task automatic load_value(input logic [63:0] dat, input logic [15:0] dpv, input logic [15:0] blk);
        in_data  = dat;
        in_dp    = dpv;
        in_blank = blk;
        in_load  = 1'b1;
    endtask

    // Advance until instance A's current state is at position pos within its frame.
    task automatic wait_frame_pos(input int pos);
        int guard;
        guard = 0;
        while ((p[0] % 64) != pos && guard < 200) begin
            run_cycle();
            guard++;
        end
        check("A_wait_pos", 32'(p[0] % 64), 32'(pos));
    endtask

    initial begin
        rst       = 1'b1;
        in_bright = 4'd15;
        in_dp     = 16'h0;
        in_blank  = 16'h0;
        in_data   = 64'h0;
        // A load during reset is ignored
        load_value(64'h9876, 16'hF, 16'h0);
        run_n(2);
        rst = 1'b0;

        // Full brightness, 0x1234 shown after the next boundary
        load_value(64'h1234, 16'h0, 16'h0);
        run_n(300);

        // Reduced duty
        in_bright = 4'd3;
        run_n(200);
        in_bright = 4'd15;

        // Two loads within one frame: last wins at the boundary
        wait_frame_pos(10);
        load_value(64'h1111, 16'h0, 16'h0);
        run_n(5);
        load_value(64'h2222, 16'h2, 16'h0);
        run_n(200);

        // Load exactly on the boundary cycle
        wait_frame_pos(63);
        load_value(64'hABCD, 16'h5, 16'h0);
        run_n(200);

        // Leading-zero pattern (no suppression in the default build) and blanking
        load_value(64'h0050, 16'h0, 16'h0);
        run_n(150);
        load_value(64'h0F0F, 16'h3, 16'h4);
        run_n(150);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                load_value({$urandom, $urandom}, 16'($urandom),
                           16'($urandom & $urandom & $urandom));
            end
            if ($urandom_range(0, 49) == 0) in_bright = 4'($urandom);
            run_cycle();
        end

        // Reset mid-slot with a coincident load
        wait_frame_pos(20);
        rst = 1'b1;
        load_value(64'h5555, 16'hF, 16'h0);
        run_cycle();
        rst = 1'b0;
        in_bright = 4'd15;
        run_n(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_display_ctrl.md
SCAN_DISPLAY_CTRL -- requirements
Module: scan_display_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of multiplexed digits, legal range 2..16.
REQ-002 Parameter DIV, default 6250: clk cycles per scan tick, legal range >= 1.
REQ-003 Parameter ACTIVE_LOW, default 1: 1 means anodes/segments/dp are driven low-true; 0 means high-true.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 digit_data  input  4*NUM_DIGITS  hex nibble per digit; digit i at bits [4i+3:4i], digit 0 rightmost.
REQ-007 dp_in  input  NUM_DIGITS  decimal point request per digit.
REQ-008 blank_in  input  NUM_DIGITS  1 forces digit fully dark.
REQ-009 load  input  1  single-cycle strobe capturing digit_data/dp_in/blank_in.
REQ-010 brightness  input  4  duty level, 0 dimmest, 15 full.
REQ-011 an  output  NUM_DIGITS  anode enables, one-hot active.
REQ-012 seg  output  7  segments, seg[6]=a .. seg[0]=g.
REQ-013 dp  output  1  decimal point segment.
REQ-014 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-015 Prescaler SHALL count 0..DIV-1 and assert internal tick on the cycle count==DIV-1, then wrap to 0.
REQ-016 Each digit slot SHALL last 16 ticks; 4-bit sub-counter advances on tick, wraps 15->0.
REQ-017 Digit index SHALL advance on tick when sub==15, sequence 0,1,..,NUM_DIGITS-1,0.
REQ-018 Frame boundary = cycle with tick, sub==15, digit==NUM_DIGITS-1.
REQ-019 load SHALL capture inputs into a pending register set on the strobe cycle; last load before a boundary wins.
REQ-020 Pending set SHALL transfer to the display set only at a frame boundary, and only if a load occurred since the previous boundary; no tearing within a frame.
REQ-021 load coinciding with a boundary cycle SHALL transfer the incoming inputs directly to the display set.
REQ-022 Anode for current digit SHALL be active while sub <= brightness and blank==0 for that digit; otherwise all anodes inactive.
REQ-023 seg SHALL decode the current digit nibble, standard hex (0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=all, 9=abcdfg, A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg).
REQ-024 dp SHALL be active iff the current digit's dp bit is set and its anode is active.
REQ-025 seg/dp SHALL be all inactive whenever no anode is active.
REQ-026 an, seg, dp, frame_done SHALL be registered; they reflect counter state with exactly 1 cycle latency.
REQ-027 frame_done SHALL assert the cycle after each frame boundary, for one cycle.
REQ-028 Polarity inversion per ACTIVE_LOW SHALL apply to an, seg, dp only; frame_done always high-true.

Reset
REQ-029 On reset: prescaler, sub, digit = 0; pending/display sets = 0 (digits 0, dp 0, blank 0); load-seen flag cleared.
REQ-030 On reset: an, seg, dp all inactive (all 1s when ACTIVE_LOW=1); frame_done=0; reset mid-frame abandons the frame, no frame_done.
REQ-031 A load asserted in the reset cycle SHALL be ignored.

Configuration
REQ-032 Macro SCAN_DISPLAY_LZB_EN defined: leading-zero blanking; digits above the most-significant nonzero nibble with dp clear are dark; digit 0 never blanked by this rule.
REQ-033 Macro undefined: no leading-zero suppression; only blank_in darkens digits.

Verification
REQ-034 NUM_DIGITS=4, DIV=1, brightness=15, load 0x1234 -> after next boundary, an cycles 1110,1101,1011,0111 each 16 cycles; seg per REQ-023 for 4,3,2,1.
REQ-035 brightness=3, DIV=1 -> each anode active 4 of 16 cycles, seg/dp inactive other 12.
REQ-036 Load 0x1111 mid-frame then 0x2222 before boundary -> current frame shows old data; next frame shows 2222 only.
REQ-037 Load at exact boundary cycle with 0xABCD -> immediately following frame displays ABCD; frame_done pulses once per 64 cycles.
REQ-038 With SCAN_DISPLAY_LZB_EN, load 0x0050 -> digits 3,2 dark, digit 1 shows 5, digit 0 shows 0; without macro digits show 0,0,5,0.
REQ-039 Reset asserted mid-slot -> next cycle an=1111, seg=1111111, dp=1, frame_done=0, counters restart at digit 0.
